// File: rtl/eth_pcs_rx_ber_monitor_pkg.sv
// eth_pcs_rx_ber_monitor_pkg: sync-header codes, BER monitor defaults and state encoding
package eth_pcs_rx_ber_monitor_pkg;
    localparam logic [1:0] SYNC_DATA = 2'b01;
    localparam logic [1:0] SYNC_CTRL = 2'b10;
    localparam int BER_TIMER_CYCLES = 40283;
    localparam int BER_HI_THRESH = 16;
    localparam int W_WIN_CNT = 5;
    typedef enum logic [1:0] {BER_INIT, BER_TEST, BER_HI} ber_state_t;
    function automatic logic sync_hdr_bad(input logic [1:0] hdr);
        return hdr != SYNC_DATA && hdr != SYNC_CTRL;
    endfunction
endpackage

// File: rtl/eth_pcs_rx_ber_monitor.sv
// eth_pcs_rx_ber_monitor: 10GBASE-R receive BER monitor with hi_ber, link status and management error counter
module eth_pcs_rx_ber_monitor
    import eth_pcs_rx_ber_monitor_pkg::*;
#(
    parameter int W_SYNC = 2,
    parameter int TIMER_CYCLES = BER_TIMER_CYCLES,
    parameter int HI_BER_THRESH = BER_HI_THRESH,
    parameter int W_BER_CNT = 6
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_rx_lock,
    input  logic                 i_hdr_valid,
    input  logic [W_SYNC-1:0]    i_hdr,
    input  logic                 i_ber_cnt_clr,
    output logic                 o_hi_ber,
    output logic                 o_pcs_status,
    output logic [W_BER_CNT-1:0] o_ber_count,
    output logic                 o_window_done
);
    localparam int W_TMR = TIMER_CYCLES > 1 ? $clog2(TIMER_CYCLES) : 1;
    ber_state_t state;
    logic [W_TMR-1:0] timer;
    logic [W_WIN_CNT-1:0] win_cnt;
    logic bad, expire, hit, cnt_inc;
    logic [W_BER_CNT-1:0] cnt_nxt;
    assign bad = i_hdr_valid && sync_hdr_bad(i_hdr);
    assign expire = timer == W_TMR'(TIMER_CYCLES - 1);
    assign hit = state == BER_TEST && bad && win_cnt == W_WIN_CNT'(HI_BER_THRESH - 1);
    assign cnt_inc = bad && i_rx_lock && state != BER_INIT;
    assign cnt_nxt = i_ber_cnt_clr ? W_BER_CNT'(cnt_inc)
                                   : o_ber_count + W_BER_CNT'(cnt_inc && !(&o_ber_count));
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state         <= BER_INIT;
            timer         <= '0;
            win_cnt       <= '0;
            o_hi_ber      <= 1'b0;
            o_pcs_status  <= 1'b0;
            o_ber_count   <= '0;
            o_window_done <= 1'b0;
        end else begin
            o_pcs_status  <= i_rx_lock && !o_hi_ber;
            o_ber_count   <= cnt_nxt;
            o_window_done <= i_rx_lock && state != BER_INIT && expire;
            if (!i_rx_lock) begin
                state    <= BER_INIT;
                timer    <= '0;
                win_cnt  <= '0;
                o_hi_ber <= 1'b0;
            end else if (state == BER_INIT) begin
                state <= BER_TEST;
                timer <= W_TMR'(1);
            end else begin
                timer <= expire ? '0 : timer + W_TMR'(1);
                // a threshold hit on the expiry cycle still starts the new window in HI
                if (hit) begin
                    state    <= BER_HI;
                    o_hi_ber <= 1'b1;
                    win_cnt  <= '0;
                end else if (expire) begin
                    state   <= BER_TEST;
                    win_cnt <= '0;
                    if (state == BER_TEST) o_hi_ber <= 1'b0;
                end else if (state == BER_TEST && bad) begin
                    win_cnt <= win_cnt + W_WIN_CNT'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_eth_pcs_rx_ber_monitor.sv
// tb_eth_pcs_rx_ber_monitor: vector table, directed corner sequences and randomized run against a window model
module tb_eth_pcs_rx_ber_monitor;
    localparam int T = 100, THR = 16, WB = 6;
    logic i_clk = 1'b0, i_reset = 1'b1, i_rx_lock = 1'b0, i_hdr_valid = 1'b0, i_ber_cnt_clr = 1'b0;
    logic [1:0] i_hdr = 2'b01;
    logic o_hi_ber, o_pcs_status, o_window_done;
    logic [WB-1:0] o_ber_count;
    int checks = 0, failures = 0;
    int m_cnt = 0, m_age = 0, m_nbad = 0;
    bit m_hi = 0, m_st = 0, m_done = 0, m_inwin = 0, m_trip = 0;

    always #5 i_clk = ~i_clk;

    eth_pcs_rx_ber_monitor #(.W_SYNC(2), .TIMER_CYCLES(T), .HI_BER_THRESH(THR), .W_BER_CNT(WB)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_rx_lock(i_rx_lock), .i_hdr_valid(i_hdr_valid),
        .i_hdr(i_hdr), .i_ber_cnt_clr(i_ber_cnt_clr), .o_hi_ber(o_hi_ber),
        .o_pcs_status(o_pcs_status), .o_ber_count(o_ber_count), .o_window_done(o_window_done));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // window model: age counts cycles since the window opened, m_trip marks a window already over threshold
    task automatic model(input bit r, input bit l, input bit v, input logic [1:0] h, input bit c);
        bit bad, hit, last;
        bad = v && (h == 2'b00 || h == 2'b11);
        if (r) begin
            m_cnt = 0; m_age = 0; m_nbad = 0; m_hi = 0; m_st = 0; m_done = 0; m_inwin = 0; m_trip = 0;
            return;
        end
        m_st = l && !m_hi;
        if (c) m_cnt = (bad && l && m_inwin) ? 1 : 0;
        else if (bad && l && m_inwin && m_cnt < (1 << WB) - 1) m_cnt++;
        m_done = 0;
        if (!l) begin
            m_inwin = 0; m_hi = 0; m_age = 0; m_nbad = 0; m_trip = 0;
        end else if (!m_inwin) begin
            m_inwin = 1; m_age = 1; m_nbad = 0; m_trip = 0;
        end else begin
            hit = 0;
            last = m_age == T - 1;
            if (bad && !m_trip) begin
                m_nbad++;
                hit = m_nbad == THR;
            end
            if (hit) begin
                m_hi = 1; m_trip = 1;
            end
            if (last) begin
                m_done = 1;
                if (!hit && !m_trip) m_hi = 0;
                if (!hit) m_trip = 0;
                m_nbad = 0;
                m_age = 0;
            end else begin
                m_age++;
            end
        end
    endtask

    task automatic step(input bit r, input bit l, input bit v, input logic [1:0] h, input bit c);
        i_reset = r; i_rx_lock = l; i_hdr_valid = v; i_hdr = h; i_ber_cnt_clr = c;
        @(posedge i_clk);
        model(r, l, v, h, c);
        #1;
        chk("model_hi_ber", o_hi_ber, m_hi);
        chk("model_pcs_status", o_pcs_status, m_st);
        chk("model_window_done", o_window_done, m_done);
        chk("model_ber_count", o_ber_count, m_cnt);
    endtask

    typedef struct {
        bit r, l, v;
        logic [1:0] h;
        bit c, hi, st, dn;
        int cnt;
    } vec_t;
    vec_t tbl[10];

    initial begin
        int first_done, ndone, rate;
        bit any_hi;
        tbl[0] = '{1, 0, 0, 2'b01, 0, 0, 0, 0, 0};
        tbl[1] = '{0, 0, 1, 2'b00, 0, 0, 0, 0, 0};
        tbl[2] = '{0, 1, 1, 2'b00, 0, 0, 1, 0, 0};
        tbl[3] = '{0, 1, 1, 2'b11, 0, 0, 1, 0, 1};
        tbl[4] = '{0, 1, 1, 2'b01, 0, 0, 1, 0, 1};
        tbl[5] = '{0, 1, 0, 2'b00, 0, 0, 1, 0, 1};
        tbl[6] = '{0, 1, 1, 2'b10, 1, 0, 1, 0, 0};
        tbl[7] = '{0, 1, 1, 2'b00, 1, 0, 1, 0, 1};
        tbl[8] = '{0, 0, 1, 2'b00, 0, 0, 0, 0, 1};
        tbl[9] = '{0, 0, 0, 2'b00, 0, 0, 0, 0, 1};
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].r, tbl[i].l, tbl[i].v, tbl[i].h, tbl[i].c);
            chk($sformatf("vec%0d_hi_ber", i), o_hi_ber, tbl[i].hi);
            chk($sformatf("vec%0d_pcs_status", i), o_pcs_status, tbl[i].st);
            chk($sformatf("vec%0d_window_done", i), o_window_done, tbl[i].dn);
            chk($sformatf("vec%0d_ber_count", i), o_ber_count, tbl[i].cnt);
        end

        // clean link: periodic window pulses, no hi_ber
        step(1, 0, 0, 2'b01, 0);
        first_done = -1; ndone = 0; any_hi = 0;
        for (int k = 0; k < 250; k++) begin
            step(0, 1, k % 2 == 0, 2'b01, 0);
            if (o_window_done) begin
                ndone++;
                if (first_done < 0) first_done = k;
            end
            any_hi |= o_hi_ber;
            if (k == 1) chk("clean_pcs_status", o_pcs_status, 1);
        end
        chk("clean_first_done", first_done, T - 1);
        chk("clean_done_count", ndone, 2);
        chk("clean_no_hi_ber", any_hi, 0);

        // 16 bad headers, then hi_ber holds through one HI and one clean TEST window
        step(1, 0, 0, 2'b01, 0);
        for (int k = 0; k < 200; k++) begin
            step(0, 1, k >= 1 && k <= 16, 2'b00, 0);
            if (k == 15) chk("trip_hi_before", o_hi_ber, 0);
            if (k == 16) chk("trip_hi_latency", o_hi_ber, 1);
            if (k == 16) chk("trip_ber_count", o_ber_count, 16);
            if (k == 17) chk("trip_status_low", o_pcs_status, 0);
            if (k == 98) chk("trip_hi_w0", o_hi_ber, 1);
            if (k == 99) chk("trip_done_w0", o_window_done, 1);
            if (k == 99) chk("trip_hi_after_w0", o_hi_ber, 1);
            if (k == 198) chk("trip_hi_w1", o_hi_ber, 1);
            if (k == 199) chk("trip_done_w1", o_window_done, 1);
            if (k == 199) chk("trip_hi_clear", o_hi_ber, 0);
        end

        // 15 bad per window never trips
        step(1, 0, 0, 2'b01, 0);
        any_hi = 0;
        for (int k = 0; k < 300; k++) begin
            step(0, 1, k % 100 >= 1 && k % 100 <= 15, 2'b00, 0);
            any_hi |= o_hi_ber;
        end
        chk("below_no_hi_ber", any_hi, 0);
        chk("below_ber_count", o_ber_count, 45);

        // 16th bad header lands on the expiry cycle, then saturation and clear-on-read
        step(1, 0, 0, 2'b01, 0);
        for (int k = 0; k < 154; k++) begin
            step(0, 1, (k >= 1 && k <= 15) || k >= 99, 2'b11, 0);
            if (k == 98) chk("edge_hi_before", o_hi_ber, 0);
            if (k == 99) chk("edge_hi_set", o_hi_ber, 1);
            if (k == 99) chk("edge_done", o_window_done, 1);
        end
        chk("sat_ber_count", o_ber_count, 63);
        chk("sat_hi_ber", o_hi_ber, 1);
        step(0, 1, 1, 2'b00, 1);
        chk("clr_with_bad", o_ber_count, 1);
        step(0, 0, 0, 2'b01, 0);
        chk("unlock_hi_ber", o_hi_ber, 0);
        chk("unlock_ber_hold", o_ber_count, 1);
        first_done = -1; ndone = 0;
        for (int k = 0; k < 100; k++) begin
            step(0, 1, 0, 2'b01, 0);
            if (o_window_done) begin
                ndone++;
                if (first_done < 0) first_done = k;
            end
        end
        chk("relock_first_done", first_done, T - 1);
        chk("relock_done_count", ndone, 1);
        for (int k = 0; k < 5; k++) step(0, 1, 1, 2'b00, 0);
        step(1, 1, 1, 2'b00, 0);
        chk("reset_hi_ber", o_hi_ber, 0);
        chk("reset_pcs_status", o_pcs_status, 0);
        chk("reset_window_done", o_window_done, 0);
        chk("reset_ber_count", o_ber_count, 0);

        rate = 20;
        for (int k = 0; k < 4000; k++) begin
            bit r, l, v, c;
            logic [1:0] h;
            if (k % 500 == 0) rate = 5 + 15 * $urandom_range(0, 2);
            r = $urandom_range(0, 999) == 0;
            l = $urandom_range(0, 299) != 0;
            v = $urandom_range(0, 1) == 1;
            h = ($urandom_range(0, 99) < rate) ? ($urandom_range(0, 1) == 1 ? 2'b00 : 2'b11)
                                               : ($urandom_range(0, 1) == 1 ? 2'b01 : 2'b10);
            c = $urandom_range(0, 49) == 0;
            step(r, l, v, h, c);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
